// File: rtl/system1_pio_pkg.sv
// Register map, status/control bit positions and status-word packing shared
// by the output FIFO and its Avalon-MM front end.
package system1_pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int STAT_EMPTY_BIT  = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_COUNT_LSB  = 8;

    localparam int CTRL_CLR_OVF_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    function automatic logic [31:0] pack_status(input logic [7:0] cnt,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: 8] = cnt;
        s[STAT_OVF_BIT]        = ovf;
        s[STAT_FULL_BIT]       = full;
        s[STAT_EMPTY_BIT]      = empty;
        return s;
    endfunction

endpackage

// File: rtl/system1_out_fifo_core.sv
// Show-ahead FIFO core: register storage, wrapping pointers and occupancy count.
// A push while full is accepted only when the head is popped in the same cycle.
module system1_out_fifo_core #(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          flush,
    input  logic [31:0]   din,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_valid,
    output logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          push_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push_ok   = push & (~full | pop);
    assign out_data  = mem[rd_ptr_reg];
    assign count     = count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately not reset; out_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/system1_output_fifo.sv
// Avalon-MM slave feeding a show-ahead output FIFO: data/status/control
// registers, sticky overflow and a shadow of the last word written.
module system1_output_fifo
    import system1_pio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          wr;
    logic          wr_data;
    logic          wr_ctrl;
    logic          flush;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   shadow_reg;
    logic          overflow_reg;
    logic [31:0]   readdata_next;

    assign wr      = chipselect & ~write_n;
    assign wr_data = wr & (reg_addr_e'(address) == REG_DATA);
    assign wr_ctrl = wr & (reg_addr_e'(address) == REG_CTRL);
    assign flush   = wr_ctrl & writedata[CTRL_FLUSH_BIT];

    system1_out_fifo_core #(
        .DEPTH (DEPTH)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_data),
        .flush     (flush),
        .din       (writedata),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Read mux uses pre-edge state, so a read alongside a push shows the old count.
    always_comb begin
        readdata_next = '0;
        case (reg_addr_e'(address))
            REG_DATA:   readdata_next = shadow_reg;
            REG_STATUS: readdata_next = pack_status(8'(count), overflow_reg, full, empty);
            default:    readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata     <= '0;
            shadow_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            readdata <= readdata_next;
            if (wr_data) shadow_reg <= writedata;
            if (wr_data && full && !pop)
                overflow_reg <= 1'b1;
            else if (wr_ctrl && writedata[CTRL_CLR_OVF_BIT])
                overflow_reg <= 1'b0;
        end
    end

endmodule

// File: doc/system1_output_fifo.md
SYSTEM1_OUTPUT_FIFO -- requirements
Module: system1_output_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..256.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  2  Avalon-MM word offset.
REQ-005 SHALL have port chipselect  input  1  slave select, active-high.
REQ-006 SHALL have port write_n  input  1  write strobe, active-low, qualified by chipselect.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port readdata  output  32  registered read data.
REQ-009 SHALL have port out_data  output  32  head-of-FIFO word to fabric consumer.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word.

Function
REQ-012 SHALL define the write event wr = chipselect & ~write_n; reads have no strobe.
REQ-013 SHALL push writedata into the FIFO on wr at address 0 when not full, or when full with a pop in the same cycle.
REQ-014 SHALL drop a push at address 0 while full with no pop, leave contents unchanged, and set sticky overflow.
REQ-015 SHALL pop on out_valid & out_ready; out_ready is ignored while out_valid is low.
REQ-016 SHALL drive out_valid = (count != 0) and out_data = head entry from registers, show-ahead.
REQ-017 SHALL assert out_valid first in the cycle after a push into an empty FIFO; no same-cycle bypass.
REQ-018 SHALL leave count unchanged on simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-019 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-020 SHALL store writedata at address 0 in a shadow register on every wr at address 0, including dropped pushes.
REQ-021 SHALL, on wr at address 2, clear overflow if writedata[0]=1 and flush if writedata[1]=1.
REQ-022 SHALL make a flush set count and both pointers to 0 next cycle, overriding a same-cycle pop; the shadow register is unaffected.
REQ-023 SHALL ignore wr at address 1 and address 3.
REQ-024 SHALL register readdata every cycle, without chipselect gating, with latency 1 from address.
REQ-025 SHALL return for address 0 the shadow register.
REQ-026 SHALL return for address 1 {16'b0, count[7:0] in bits 15:8, 5'b0, overflow bit 2, full bit 1, empty bit 0}.
REQ-027 SHALL return 0 for addresses 2 and 3.
REQ-028 SHALL compute status from pre-edge state; a read in the same cycle as a push shows the old count.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear readdata, shadow, count, pointers and overflow, and force out_valid to 0.
REQ-030 SHALL not clear FIFO storage contents on reset; out_data is don't-care while out_valid is 0.
REQ-031 SHALL discard all queued words on reset mid-operation; the first post-reset push becomes the head.

Structure
REQ-032 SHALL place register offsets (DATA=0, STATUS=1, CTRL=2) and status/control bit positions in shared package system1_pio_pkg.
REQ-033 SHALL implement storage, pointers and count in sub-module system1_out_fifo_core; the top holds the Avalon decode, shadow, overflow and readdata.

Verification
REQ-034 SHALL cover single push: write 0xA5A5_0001 at addr 0, out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5_0001; status read = 0x0000_0100.
REQ-035 SHALL cover fill, overflow and clear: 5 writes 1..5 with DEPTH=4 and out_ready=0 -> status = 0x0000_0406; pops yield 1,2,3,4; addr 0 read = 5; CTRL write 0x1 -> overflow=0.
REQ-036 SHALL cover full with simultaneous push and pop: full with 1..4, write 9 while out_ready=1 -> pops 1, count stays 4, then drains 2,3,4,9, overflow=0.
REQ-037 SHALL cover flush: 3 words queued, CTRL write 0x2 with out_ready=1 the same cycle -> next cycle out_valid=0, count=0, no further pops.
REQ-038 SHALL cover reset mid-operation: 2 words queued, pulse reset_n low -> readdata=0, out_valid=0 immediately; post-reset write 0x77 -> out_data=0x77.
REQ-039 SHALL cover pointer wrap: 10 push/pop pairs with out_ready=1 -> output order equals input order, count never exceeds 1.
